arf_sched_ctrl: RTL and testbench

//  Static-schedule controller for the ARF-variance DFG: 16 multiply and 12 add ops on a shared pool of units.

---
 rtl/arf_sched_pkg.sv | 135 +++++++++++++
 rtl/sched_lat_pipe.sv | 34 +++
 rtl/arf_sched_ctrl.sv | 166 ++++++++++++++++
 tb/tb_arf_sched_ctrl.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/arf_sched_pkg.sv
// Shared types and the ILP-produced static schedule for the ARF-variance DFG.
// Mul ops: 1-8, 13-16, 21-24; add ops: 9-12, 17-20, 25-28.
package arf_sched_pkg;

   localparam int OP_W      = 5;
   localparam int N_MUL     = 2;
   localparam int N_ADD     = 2;
   localparam int N_STEPS   = 16;
   localparam int N_OPS     = 28;
   localparam int N_MUL_OPS = 16;
   localparam int N_ADD_OPS = 12;

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD,
      S_RUN,
      S_DRAIN,
      S_DONE
   } state_t;

   typedef struct packed {
      logic            en;
      logic [OP_W-1:0] op;
   } slot_t;

   typedef struct packed {
      slot_t [N_MUL-1:0] mul;
      slot_t [N_ADD-1:0] add;
   } entry_t;

   function automatic slot_t mk_slot(int op);
      slot_t s;
      s.en = (op != 0);
      s.op = OP_W'(op);
      return s;
   endfunction

   function automatic entry_t mk_entry(int m0, int m1, int a0, int a1);
      entry_t e;
      e.mul[0] = mk_slot(m0);
      e.mul[1] = mk_slot(m1);
      e.add[0] = mk_slot(a0);
      e.add[1] = mk_slot(a1);
      return e;
   endfunction

   localparam entry_t SCHED_ROM [N_STEPS] = '{
      mk_entry( 1,  2,  9, 0),
      mk_entry( 3,  4,  0, 0),
      mk_entry( 5,  6, 19, 0),
      mk_entry( 7,  8, 10, 0),
      mk_entry(16, 23, 11, 0),
      mk_entry(13, 14, 12, 0),
      mk_entry(15,  0,  0, 0),
      mk_entry( 0,  0, 17, 0),
      mk_entry(21,  0, 18, 0),
      mk_entry(22,  0, 20, 0),
      mk_entry(24,  0,  0, 0),
      mk_entry( 0,  0, 25, 0),
      mk_entry( 0,  0, 26, 0),
      mk_entry( 0,  0, 27, 0),
      mk_entry( 0,  0, 28, 0),
      mk_entry( 0,  0,  0, 0)
   };

   // DFG operand producers per op id; 0 means primary input
   localparam int DEP_A [N_OPS+1] = '{
      0, 0, 0, 0, 0, 0, 0, 0, 0,
      0, 3, 5, 7, 10, 11, 12, 9,
      13, 15, 1, 17, 17, 18, 19, 20,
      21, 23, 25, 27
   };
   localparam int DEP_B [N_OPS+1] = '{
      0, 0, 0, 0, 0, 0, 0, 0, 0,
      0, 4, 6, 8, 0, 0, 0, 0,
      14, 16, 2, 18, 0, 0, 0, 0,
      22, 24, 26, 0
   };

   function automatic bit is_mul(int op);
      return (op >= 1 && op <= 8) || (op >= 13 && op <= 16) ||
             (op >= 21 && op <= 24);
   endfunction

   function automatic bit rom_ok(int mlat, int alat);
      int at  [N_OPS+1];
      int cnt [N_OPS+1];
      int op;
      int d;
      int nm;
      int na;
      bit ok;
      ok = 1'b1;
      nm = 0;
      na = 0;
      for (int i = 0; i <= N_OPS; i++) begin
         at[i]  = 0;
         cnt[i] = 0;
      end
      for (int s = 0; s < N_STEPS; s++) begin
         for (int u = 0; u < N_MUL; u++) begin
            if (SCHED_ROM[s].mul[u].en) begin
               op = int'(SCHED_ROM[s].mul[u].op);
               if (op < 1 || op > N_OPS || !is_mul(op)) ok = 1'b0;
               else begin
                  cnt[op]++;
                  at[op] = s;
                  nm++;
               end
            end
         end
         for (int u = 0; u < N_ADD; u++) begin
            if (SCHED_ROM[s].add[u].en) begin
               op = int'(SCHED_ROM[s].add[u].op);
               if (op < 1 || op > N_OPS || is_mul(op)) ok = 1'b0;
               else begin
                  cnt[op]++;
                  at[op] = s;
                  na++;
               end
            end
         end
      end
      if (nm != N_MUL_OPS || na != N_ADD_OPS) ok = 1'b0;
      for (int o = 1; o <= N_OPS; o++) begin
         if (cnt[o] != 1) ok = 1'b0;
         d = DEP_A[o];
         if (d != 0 && at[o] < at[d] + (is_mul(d) ? mlat : alat)) ok = 1'b0;
         d = DEP_B[o];
         if (d != 0 && at[o] < at[d] + (is_mul(d) ? mlat : alat)) ok = 1'b0;
      end
      return ok;
   endfunction

endpackage

// File: rtl/sched_lat_pipe.sv
// Valid + op-id delay line; models one functional unit's result latency.
module sched_lat_pipe #(
   parameter int LAT  = 1,
   parameter int OP_W = 5
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            vld,
   input  logic [OP_W-1:0] op,
   output logic            dly_vld,
   output logic [OP_W-1:0] dly_op
);

   logic [LAT-1:0]  v_q;
   logic [OP_W-1:0] op_q [LAT];

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         v_q <= '0;
         for (int i = 0; i < LAT; i++) op_q[i] <= '0;
      end else begin
         v_q[0]  <= vld;
         op_q[0] <= op;
         for (int i = 1; i < LAT; i++) begin
            v_q[i]  <= v_q[i-1];
            op_q[i] <= op_q[i-1];
         end
      end
   end

   assign dly_vld = v_q[LAT-1];
   assign dly_op  = op_q[LAT-1];

endmodule

// File: rtl/arf_sched_ctrl.sv
// Static-schedule controller: loads inputs, steps the schedule ROM,
// issues ops to shared mul/add slots and tracks their writebacks.
module arf_sched_ctrl #(
   parameter int NUM_MUL   = 2,
   parameter int NUM_ADD   = 2,
   parameter int NUM_STEPS = 16,
   parameter int NUM_IN    = 10,
   parameter int OP_W      = 5,
   parameter int MUL_LAT   = 2,
   parameter int ADD_LAT   = 1,
   localparam int IDX_W  = (NUM_IN > 1) ? $clog2(NUM_IN) : 1,
   localparam int STEP_W = (NUM_STEPS > 1) ? $clog2(NUM_STEPS) : 1
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    start,
   input  logic                    in_valid,
   output logic                    in_ready,
   output logic [IDX_W-1:0]        in_idx,
   output logic [NUM_MUL-1:0]      mul_issue,
   output logic [NUM_MUL*OP_W-1:0] mul_op,
   output logic [NUM_ADD-1:0]      add_issue,
   output logic [NUM_ADD*OP_W-1:0] add_op,
   output logic [NUM_MUL-1:0]      mul_wb,
   output logic [NUM_MUL*OP_W-1:0] mul_wb_op,
   output logic [NUM_ADD-1:0]      add_wb,
   output logic [NUM_ADD*OP_W-1:0] add_wb_op,
   output logic [STEP_W-1:0]       step,
   output logic                    busy,
   output logic                    done
);

   import arf_sched_pkg::*;

   localparam int DRAIN_N = (MUL_LAT > ADD_LAT) ? MUL_LAT : ADD_LAT;
   localparam int DRN_W   = $clog2(DRAIN_N + 1);

   localparam bit CFG_OK =
      NUM_MUL == N_MUL && NUM_ADD == N_ADD &&
      NUM_STEPS == N_STEPS && OP_W == arf_sched_pkg::OP_W &&
      NUM_IN >= 0 && MUL_LAT >= 1 && ADD_LAT >= 1 &&
      rom_ok(MUL_LAT, ADD_LAT);

   if (!CFG_OK) begin : g_cfg_err
      $error("arf_sched_ctrl: illegal schedule ROM or parameters");
   end

   state_t             state_q, state_d;
   logic [IDX_W-1:0]   idx_q, idx_d;
   logic [STEP_W-1:0]  step_q, step_d;
   logic [DRN_W-1:0]   drn_q, drn_d;
   logic               run;
   entry_t             cur;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         idx_q   <= '0;
         step_q  <= '0;
         drn_q   <= '0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         step_q  <= step_d;
         drn_q   <= drn_d;
      end
   end

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      step_d  = step_q;
      drn_d   = drn_q;
      unique case (state_q)
         S_IDLE: begin
            if (start) begin
               state_d = (NUM_IN == 0) ? S_RUN : S_LOAD;
               idx_d   = '0;
               step_d  = '0;
            end
         end
         S_LOAD: begin
            if (in_valid) begin
               if (idx_q == IDX_W'(NUM_IN - 1)) begin
                  state_d = S_RUN;
                  idx_d   = '0;
               end else begin
                  idx_d = idx_q + IDX_W'(1);
               end
            end
         end
         S_RUN: begin
            if (step_q == STEP_W'(NUM_STEPS - 1)) begin
               state_d = S_DRAIN;
               step_d  = '0;
               drn_d   = '0;
            end else begin
               step_d = step_q + STEP_W'(1);
            end
         end
         S_DRAIN: begin
            if (drn_q == DRN_W'(DRAIN_N - 1)) state_d = S_DONE;
            else drn_d = drn_q + DRN_W'(1);
         end
         S_DONE: state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   assign run      = (state_q == S_RUN);
   assign cur      = SCHED_ROM[step_q];
   assign in_ready = (state_q == S_LOAD);
   assign in_idx   = idx_q;
   assign step     = step_q;
   assign busy     = (state_q != S_IDLE);
   assign done     = (state_q == S_DONE);

   // op ids are forced to 0 on idle slots so downstream muxes see a clean "none"
   always_comb begin
      mul_issue = '0;
      mul_op    = '0;
      add_issue = '0;
      add_op    = '0;
      for (int i = 0; i < NUM_MUL; i++) begin
         if (run && cur.mul[i].en) begin
            mul_issue[i]            = 1'b1;
            mul_op[i*OP_W +: OP_W] = cur.mul[i].op;
         end
      end
      for (int i = 0; i < NUM_ADD; i++) begin
         if (run && cur.add[i].en) begin
            add_issue[i]            = 1'b1;
            add_op[i*OP_W +: OP_W] = cur.add[i].op;
         end
      end
   end

   for (genvar g = 0; g < NUM_MUL; g++) begin : g_mul_wb
      sched_lat_pipe #(
         .LAT  (MUL_LAT),
         .OP_W (OP_W)
      ) u_pipe (
         .clk     (clk),
         .rst_n   (rst_n),
         .vld     (mul_issue[g]),
         .op      (mul_op[g*OP_W +: OP_W]),
         .dly_vld (mul_wb[g]),
         .dly_op  (mul_wb_op[g*OP_W +: OP_W])
      );
   end

   for (genvar g = 0; g < NUM_ADD; g++) begin : g_add_wb
      sched_lat_pipe #(
         .LAT  (ADD_LAT),
         .OP_W (OP_W)
      ) u_pipe (
         .clk     (clk),
         .rst_n   (rst_n),
         .vld     (add_issue[g]),
         .op      (add_op[g*OP_W +: OP_W]),
         .dly_vld (add_wb[g]),
         .dly_op  (add_wb_op[g*OP_W +: OP_W])
      );
   end

endmodule

// File: tb/tb_arf_sched_ctrl.sv
// Directed bench for arf_sched_ctrl with default parameters.
module tb_arf_sched_ctrl;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       start = 1'b0;
   logic       in_valid = 1'b0;
   logic       in_ready;
   logic [3:0] in_idx;
   logic [1:0] mul_issue, add_issue, mul_wb, add_wb;
   logic [9:0] mul_op, add_op, mul_wb_op, add_wb_op;
   logic [3:0] step;
   logic       busy, done;

   int n_chk = 0;
   int n_fail = 0;
   int cyc = 0;

   int iss_cnt [32];
   int iss_cyc [32];
   bit iss_mul [32];
   bit iss_add [32];
   int wb_cnt  [32];
   int wb_cyc  [32];
   bit wb_mul  [32];
   int zero_err, done_cnt, wb_tot, iss_tot;
   int mop;

   arf_sched_ctrl dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_idx    (in_idx),
      .mul_issue (mul_issue),
      .mul_op    (mul_op),
      .add_issue (add_issue),
      .add_op    (add_op),
      .mul_wb    (mul_wb),
      .mul_wb_op (mul_wb_op),
      .add_wb    (add_wb),
      .add_wb_op (add_wb_op),
      .step      (step),
      .busy      (busy),
      .done      (done)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Per-op tallies of issue and writeback events, sampled mid-cycle
   always @(negedge clk) begin
      for (int i = 0; i < 2; i++) begin
         mop = int'(mul_op[i*5 +: 5]);
         if (mul_issue[i]) begin
            iss_cnt[mop]++; iss_cyc[mop] = cyc; iss_mul[mop] = 1'b1; iss_tot++;
         end else if (mop != 0) zero_err++;
         mop = int'(add_op[i*5 +: 5]);
         if (add_issue[i]) begin
            iss_cnt[mop]++; iss_cyc[mop] = cyc; iss_add[mop] = 1'b1; iss_tot++;
         end else if (mop != 0) zero_err++;
         mop = int'(mul_wb_op[i*5 +: 5]);
         if (mul_wb[i]) begin
            wb_cnt[mop]++; wb_cyc[mop] = cyc; wb_mul[mop] = 1'b1; wb_tot++;
         end else if (mop != 0) zero_err++;
         mop = int'(add_wb_op[i*5 +: 5]);
         if (add_wb[i]) begin
            wb_cnt[mop]++; wb_cyc[mop] = cyc; wb_tot++;
         end else if (mop != 0) zero_err++;
      end
      if (done) done_cnt++;
   end

   function automatic bit exp_mul(int op);
      return (op >= 1 && op <= 8) || (op >= 13 && op <= 16) ||
             (op >= 21 && op <= 24);
   endfunction

   task automatic clear_tallies();
      for (int i = 0; i < 32; i++) begin
         iss_cnt[i] = 0; iss_cyc[i] = 0; iss_mul[i] = 0; iss_add[i] = 0;
         wb_cnt[i] = 0; wb_cyc[i] = 0; wb_mul[i] = 0;
      end
      zero_err = 0; done_cnt = 0; wb_tot = 0; iss_tot = 0;
   endtask

   // Start is high during cycle k; returns k
   task automatic start_eval(output int k);
      @(posedge clk);
      #2 clear_tallies();
      @(negedge clk);
      k = cyc;
      start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
   endtask

   task automatic wait_done(output int t);
      t = -1;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (done === 1'b1) begin
            t = cyc;
            break;
         end
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0; in_valid = 1'b1; start = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      n_chk++;
      if ({busy, done, in_ready, mul_issue, add_issue, mul_wb, add_wb} !== 11'd0) begin
         n_fail++;
         $display("FAIL reset_hold: got %b want 0", {busy, done, in_ready, mul_issue, add_issue, mul_wb, add_wb});
      end
      rst_n = 1'b1;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         n_chk++;
         if ({in_ready, busy, done, mul_issue, add_issue, mul_wb, add_wb, step, in_idx,
              mul_op, add_op, mul_wb_op, add_wb_op} !== 59'd0) begin
            n_fail++;
            $display("FAIL idle_quiet cyc%0d: rdy=%b busy=%b done=%b mi=%b ai=%b mw=%b aw=%b step=%0d idx=%0d want all 0",
                     i, in_ready, busy, done, mul_issue, add_issue, mul_wb, add_wb, step, in_idx);
         end
      end
   endtask

   task automatic test_full_run();
      int k, t, bad_iss, bad_unit, bad_wb;
      in_valid = 1'b1;
      start_eval(k);
      wait_done(t);
      n_chk++;
      if (t != k + 29) begin n_fail++; $display("FAIL run_latency: done at %0d want %0d", t, k + 29); end
      repeat (3) @(negedge clk);
      bad_iss = 0; bad_unit = 0; bad_wb = 0;
      for (int op = 1; op <= 28; op++) begin
         if (iss_cnt[op] != 1) bad_iss++;
         if (exp_mul(op) ? (!iss_mul[op] || iss_add[op]) : (!iss_add[op] || iss_mul[op])) bad_unit++;
         if (wb_cnt[op] != 1 || wb_mul[op] != exp_mul(op) ||
             wb_cyc[op] != iss_cyc[op] + (exp_mul(op) ? 2 : 1)) bad_wb++;
      end
      n_chk++;
      if (bad_iss != 0) begin n_fail++; $display("FAIL issue_once: %0d bad ops want 0", bad_iss); end
      n_chk++;
      if (bad_unit != 0) begin n_fail++; $display("FAIL issue_unit: %0d bad ops want 0", bad_unit); end
      n_chk++;
      if (bad_wb != 0) begin n_fail++; $display("FAIL wb_align: %0d bad ops want 0", bad_wb); end
      n_chk++;
      if (iss_tot != 28 || wb_tot != 28) begin
         n_fail++; $display("FAIL totals: iss=%0d wb=%0d want 28/28", iss_tot, wb_tot);
      end
      n_chk++;
      if (zero_err != 0) begin n_fail++; $display("FAIL op_zero: %0d nonzero idle ops want 0", zero_err); end
      n_chk++;
      if (done_cnt != 1) begin n_fail++; $display("FAIL done_pulse: %0d want 1", done_cnt); end
      n_chk++;
      if (iss_cyc[1] != k + 11 || iss_cyc[28] != k + 25) begin
         n_fail++;
         $display("FAIL issue_cyc: op1 %0d op28 %0d want %0d %0d", iss_cyc[1], iss_cyc[28], k + 11, k + 25);
      end
   endtask

   task automatic test_multi_issue();
      int k, t;
      start_eval(k);
      repeat (11) @(negedge clk);
      n_chk++;
      if (step !== 4'd0 || mul_issue !== 2'b11 || mul_op !== {5'd2, 5'd1} ||
          add_issue !== 2'b01 || add_op !== {5'd0, 5'd9}) begin
         n_fail++;
         $display("FAIL multi_issue: step=%0d mi=%b mop=%h ai=%b aop=%h want 0 11 041 01 009",
                  step, mul_issue, mul_op, add_issue, add_op);
      end
      @(negedge clk);
      n_chk++;
      if (add_wb !== 2'b01 || add_wb_op !== {5'd0, 5'd9} || mul_wb !== 2'b00) begin
         n_fail++;
         $display("FAIL add_wb_step0: aw=%b awop=%h mw=%b want 01 009 00", add_wb, add_wb_op, mul_wb);
      end
      @(negedge clk);
      n_chk++;
      if (mul_wb !== 2'b11 || mul_wb_op !== {5'd2, 5'd1}) begin
         n_fail++;
         $display("FAIL mul_wb_step0: mw=%b mwop=%h want 11 041", mul_wb, mul_wb_op);
      end
      wait_done(t);
      n_chk++;
      if (t != k + 29) begin n_fail++; $display("FAIL multi_done: %0d want %0d", t, k + 29); end
   endtask

   task automatic test_load_stall();
      int k, t;
      in_valid = 1'b1;
      start_eval(k);
      repeat (5) @(negedge clk);
      n_chk++;
      if (in_idx !== 4'd4 || in_ready !== 1'b1) begin
         n_fail++; $display("FAIL stall_entry: idx=%0d rdy=%b want 4 1", in_idx, in_ready);
      end
      in_valid = 1'b0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         n_chk++;
         if (in_idx !== 4'd4 || in_ready !== 1'b1) begin
            n_fail++; $display("FAIL stall_hold %0d: idx=%0d rdy=%b want 4 1", i, in_idx, in_ready);
         end
      end
      in_valid = 1'b1;
      wait_done(t);
      n_chk++;
      if (t != k + 34) begin n_fail++; $display("FAIL stall_done: %0d want %0d", t, k + 34); end
   endtask

   task automatic test_start_ignored();
      int k, t, k2, t2, bad;
      start_eval(k);
      repeat (15) @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      wait_done(t);
      n_chk++;
      if (t != k + 29) begin n_fail++; $display("FAIL run_start_ign: done %0d want %0d", t, k + 29); end
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      n_chk++;
      if (busy !== 1'b0 || done !== 1'b0 || done_cnt != 1) begin
         n_fail++; $display("FAIL done_start_ign: busy=%b done=%b cnt=%0d want 0 0 1", busy, done, done_cnt);
      end
      start_eval(k2);
      wait_done(t2);
      n_chk++;
      if (t2 != k2 + 29) begin n_fail++; $display("FAIL second_run: done %0d want %0d", t2, k2 + 29); end
      repeat (2) @(negedge clk);
      bad = 0;
      for (int op = 1; op <= 28; op++) if (iss_cnt[op] != 1 || wb_cnt[op] != 1) bad++;
      n_chk++;
      if (bad != 0 || iss_tot != 28) begin
         n_fail++; $display("FAIL second_ops: bad=%0d iss=%0d want 0 28", bad, iss_tot);
      end
   endtask

   task automatic test_reset_abort();
      int k;
      start_eval(k);
      repeat (18) @(negedge clk);
      n_chk++;
      if (step !== 4'd7 || busy !== 1'b1) begin
         n_fail++; $display("FAIL abort_pre: step=%0d busy=%b want 7 1", step, busy);
      end
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      n_chk++;
      if ({busy, done, in_ready, step, mul_issue, add_issue, mul_wb, add_wb} !== 15'd0) begin
         n_fail++;
         $display("FAIL abort_now: busy=%b step=%0d mi=%b ai=%b mw=%b aw=%b want 0",
                  busy, step, mul_issue, add_issue, mul_wb, add_wb);
      end
      @(posedge clk);
      #2 clear_tallies();
      repeat (10) @(negedge clk);
      n_chk++;
      if (wb_tot != 0 || iss_tot != 0 || done_cnt != 0 || busy !== 1'b0) begin
         n_fail++;
         $display("FAIL abort_after: wb=%0d iss=%0d done=%0d busy=%b want 0", wb_tot, iss_tot, done_cnt, busy);
      end
   endtask

   initial begin
      clear_tallies();
      test_reset();
      test_full_run();
      test_multi_issue();
      test_load_stall();
      test_start_ignored();
      test_reset_abort();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

endmodule
